// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad blocks (emulator, scanner,
// password FSM): row/col width, idle row pattern, key-code field positions
// and the emulator FSM state type.
package keypad_pkg;

  // Row and column buses are both 4 lines wide on a 4x4 matrix.
  localparam int KP_W = 4;

  // All row lines released (active-low bus, no key pressed).
  localparam logic [KP_W-1:0] ROW_IDLE = 4'b1111;

  // Key-code field positions: [3:2] selects the row, [1:0] the column.
  localparam int ROW_IDX_HI = 3;
  localparam int ROW_IDX_LO = 2;
  localparam int COL_IDX_HI = 1;
  localparam int COL_IDX_LO = 0;

  // Emulator press sequence.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BOUNCE  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } kp_state_e;

  // Active-low row pattern with only the selected row line pulled low.
  function automatic logic [KP_W-1:0] row_pull(input logic [1:0] row_idx);
    return ROW_IDLE & ~(4'b0001 << row_idx);
  endfunction

endpackage

// File: rtl/keypad_emulator.sv
// Physical 4x4 keypad model. A host requests a key press by code; while the
// key is held, the row line of that key is pulled low whenever the scanner
// drives the key's column low. Each press runs an optional chatter phase, a
// hold phase and a guaranteed release gap before the next request is taken.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 60,
  parameter int RELEASE_CYCLES = 40,
  parameter int BOUNCE_CYCLES  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [KP_W-1:0] key_code,
  input  logic            key_req,
  output logic            key_ready,
  input  logic [KP_W-1:0] col,
  output logic [KP_W-1:0] row,
  output logic            busy,
  output logic            done
);

  // One counter serves every phase, so it is sized for the longest one.
  localparam int MAX_HR = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int MAX_P  = (MAX_HR > BOUNCE_CYCLES) ? MAX_HR : BOUNCE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST  =
    CNT_W'((BOUNCE_CYCLES > 0) ? (BOUNCE_CYCLES - 1) : 0);

  kp_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [KP_W-1:0]  code_r;
  logic             pressed_r;
  logic             key_ready_r;
  logic             busy_r;
  logic             done_r;
  logic [KP_W-1:0]  row_r;
  logic [KP_W-1:0]  row_next_s;

  // Press sequencer: phase state, phase counter, latched code, contact state
  // and the registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      code_r      <= 4'b0000;
      pressed_r   <= 1'b0;
      key_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (key_req && key_ready_r) begin
            code_r      <= key_code;
            cnt_r       <= CNT_ZERO;
            pressed_r   <= 1'b1;
            key_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= (BOUNCE_CYCLES > 0) ? ST_BOUNCE : ST_HOLD;
          end else begin
            pressed_r   <= 1'b0;
            key_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        ST_BOUNCE: begin
          // Chatter: contact alternates every cycle, first cycle closed.
          if (cnt_r == BOUNCE_LAST) begin
            cnt_r     <= CNT_ZERO;
            pressed_r <= 1'b1;
            state_r   <= ST_HOLD;
          end else begin
            cnt_r     <= cnt_r + CNT_ONE;
            pressed_r <= ~pressed_r;
          end
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            cnt_r     <= CNT_ZERO;
            pressed_r <= 1'b0;
            state_r   <= ST_RELEASE;
          end else begin
            cnt_r     <= cnt_r + CNT_ONE;
            pressed_r <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_r == RELEASE_LAST) begin
            cnt_r       <= CNT_ZERO;
            key_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            cnt_r     <= cnt_r + CNT_ONE;
            pressed_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= CNT_ZERO;
          pressed_r   <= 1'b0;
          key_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Row decode: only the column selected by the latched code is examined,
  // so extra low columns from the scanner do not matter.
  always_comb begin
    row_next_s = ROW_IDLE;
    if (pressed_r && (col[code_r[COL_IDX_HI:COL_IDX_LO]] == 1'b0)) begin
      row_next_s = row_pull(code_r[ROW_IDX_HI:ROW_IDX_LO]);
    end else begin
      row_next_s = ROW_IDLE;
    end
  end

  // Row register: follows a column change one cycle later; reset releases
  // the row lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r <= ROW_IDLE;
    end else begin
      row_r <= row_next_s;
    end
  end

  assign row       = row_r;
  assign key_ready = key_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (no chatter / 6-cycle chatter)
// share stimulus. A timeline model predicts each cycle's outputs and pushes
// them to per-instance queues; a monitor pops and compares after each edge.
module tb_keypad_emulator;

  localparam int H = 60;
  localparam int R = 40;

  typedef struct {
    logic [3:0] row;
    logic       ready;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] kc = 4'h0;
  logic       kr = 1'b0;
  logic [3:0] cl = 4'hF;

  logic       ready_s [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [3:0] row_s   [2];

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_err    = 0;

  // Model state per instance: active press, edges since acceptance, code.
  bit         m_act  [2];
  int         m_k    [2];
  logic [3:0] m_code [2];
  int         bnc    [2];

  always #5 clk = ~clk;

  keypad_emulator #(.HOLD_CYCLES(H), .RELEASE_CYCLES(R), .BOUNCE_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_code(kc), .key_req(kr), .key_ready(ready_s[0]),
    .col(cl), .row(row_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  keypad_emulator #(.HOLD_CYCLES(H), .RELEASE_CYCLES(R), .BOUNCE_CYCLES(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_code(kc), .key_req(kr), .key_ready(ready_s[1]),
    .col(cl), .row(row_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  task automatic chk(input string name, input int inst, input logic [3:0] act,
                     input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  // Contact state in the k-th cycle after acceptance, from the press rules.
  function automatic bit pressed_at(input int k, input int b);
    if (k < b) return (k % 2) == 0;
    if (k < b + H) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t reset_item();
    exp_t e;
    e.row = 4'hF; e.ready = 1'b1; e.busy = 1'b0; e.done = 1'b0;
    return e;
  endfunction

  // Predict outputs after the coming rising edge from the inputs now driven.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      bit   p;
      p = m_act[i] && pressed_at(m_k[i], bnc[i]);
      e.row  = (p && cl[m_code[i][1:0]] == 1'b0) ? (4'hF ^ (4'h1 << m_code[i][3:2])) : 4'hF;
      e.done = 1'b0;
      if (!m_act[i]) begin
        if (kr) begin
          m_act[i] = 1'b1; m_k[i] = 0; m_code[i] = kc;
        end
      end else if (m_k[i] == bnc[i] + H + R - 1) begin
        m_act[i] = 1'b0; e.done = 1'b1;
      end else begin
        m_k[i]++;
      end
      e.ready = !m_act[i];
      e.busy  = m_act[i];
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Called at a falling edge: drive inputs, predict, advance to next falling edge.
  task automatic step(input logic req, input logic [3:0] code, input logic [3:0] c);
    kr = req; kc = code; cl = c;
    model_edge();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must release at once.
  task automatic do_reset();
    rst_n = 1'b0;
    kr = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_row", i, row_s[i], 4'hF);
      chk("async_ready", i, {3'b000, ready_s[i]}, 4'h1);
      chk("async_busy", i, {3'b000, busy_s[i]}, 4'h0);
      m_act[i] = 1'b0; m_k[i] = 0; m_code[i] = 4'h0;
    end
    q0.push_back(reset_item()); q1.push_back(reset_item());
    @(negedge clk);
    q0.push_back(reset_item()); q1.push_back(reset_item());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare each instance's outputs against its queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        bit   have;
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk("row", i, row_s[i], e.row);
          chk("key_ready", i, {3'b000, ready_s[i]}, {3'b000, e.ready});
          chk("busy", i, {3'b000, busy_s[i]}, {3'b000, e.busy});
          chk("done", i, {3'b000, done_s[i]}, {3'b000, e.done});
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    logic [3:0] scan;
    logic [3:0] c;
    bnc[0] = 0; bnc[1] = 6;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_k[i] = 0; m_code[i] = 4'h0;
    end
    @(negedge clk);
    do_reset();

    // Single press of key 6 with column 2 held low.
    step(1'b1, 4'h6, 4'b1011);
    for (int n = 0; n < 115; n++) step(1'b0, 4'hA, 4'b1011);

    // Free-running one-hot column scan, key D.
    scan = 4'b1110;
    step(1'b1, 4'hD, scan);
    for (int n = 1; n < 116; n++) begin
      if (n % 4 == 0) scan = {scan[2:0], scan[3]};
      step(1'b0, 4'h0, scan);
    end

    // Request held high with codes 1..4; busy-time requests are not queued.
    for (int n = 0; n < 440; n++) step(1'b1, 4'(1 + (n / 101) % 4), 4'b0000);
    for (int n = 0; n < 110; n++) step(1'b0, 4'h0, 4'b0000);

    // Key 0 with column 0 low exercises chatter on the second instance.
    step(1'b1, 4'h0, 4'b1110);
    for (int n = 0; n < 110; n++) step(1'b0, 4'h0, 4'b1110);

    // Reset 20 cycles into hold; no done may follow.
    step(1'b1, 4'h5, 4'b1101);
    for (int n = 0; n < 20; n++) step(1'b0, 4'h5, 4'b1101);
    do_reset();
    for (int n = 0; n < 110; n++) step(1'b0, 4'h5, 4'b1101);

    // No column driven during a press of key 9.
    step(1'b1, 4'h9, 4'b1111);
    for (int n = 0; n < 110; n++) step(1'b0, 4'h9, 4'b1111);

    // Randomized requests, codes and column patterns, with rare resets.
    scan = 4'b1110;
    for (int n = 0; n < 3000; n++) begin
      if (n % 4 == 0) scan = {scan[2:0], scan[3]};
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : scan;
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), c);
      end
    end
    step(1'b0, 4'h0, 4'hF);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
